// File: rtl/gpib_source_handshake_if.sv
// rtl/gpib_source_handshake_if.sv - GPIB source handshake byte stream and bus signals
interface gpib_source_handshake_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_last;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  talk_en;
  logic                  atn;
  logic                  ifc;
  logic                  nrfd;
  logic                  ndac;
  logic [DATA_WIDTH-1:0] gpib_data_out;
  logic                  gpib_data_oe;
  logic                  dav;
  logic                  eoi_out;
  logic                  busy;
  logic                  timeout_err;
  logic                  no_listener_err;

  modport master (
    output tx_data, tx_last, tx_valid, talk_en, atn, ifc, nrfd, ndac,
    input  tx_ready, gpib_data_out, gpib_data_oe, dav, eoi_out, busy,
           timeout_err, no_listener_err
  );

  modport slave (
    input  tx_data, tx_last, tx_valid, talk_en, atn, ifc, nrfd, ndac,
    output tx_ready, gpib_data_out, gpib_data_oe, dav, eoi_out, busy,
           timeout_err, no_listener_err
  );
endinterface

// File: rtl/gpib_source_handshake.sv
// rtl/gpib_source_handshake.sv - GPIB talker source handshake (SH) with transmit byte FIFO
module gpib_source_handshake #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  gpib_source_handshake_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SGNS, SDYS, STRS, SWNS} state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [SW-1:0]         settle_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  dav_q, oe_q, eoi_q, tmo_err_q, nl_err_q;
  logic                  push, pop, abort, settle_done, tmo_hit, full;

  assign full        = (count == FULL_CNT);
  assign push        = bus.tx_valid && !full && !bus.ifc;
  assign abort       = bus.atn || !bus.talk_en;
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign tmo_hit     = (tmo_cnt == TMO_LAST);

  // Pop decisions mirror the FSM exits that consume the head byte; aborts never pop.
  always_comb begin
    pop = 1'b0;
    if (!bus.ifc && !abort) begin
      case (state)
        SGNS:    pop = !bus.nrfd && !bus.ndac;
        SDYS:    pop = tmo_hit && !(settle_done && !bus.nrfd);
        STRS:    pop = tmo_hit && bus.ndac;
        SWNS:    pop = 1'b1;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.tx_last, bus.tx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.ifc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      data_q     <= '0;
      dav_q      <= 1'b0;
      oe_q       <= 1'b0;
      eoi_q      <= 1'b0;
      tmo_err_q  <= 1'b0;
      nl_err_q   <= 1'b0;
    end else if (bus.ifc || (state != IDLE && abort)) begin
      state  <= IDLE;
      data_q <= '0;
      dav_q  <= 1'b0;
      oe_q   <= 1'b0;
      eoi_q  <= 1'b0;
      if (bus.ifc) begin
        tmo_err_q <= 1'b0;
        nl_err_q  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count != '0 && !abort) begin
            state  <= SGNS;
            oe_q   <= 1'b1;
            data_q <= mem[rd_ptr][DATA_WIDTH-1:0];
            eoi_q  <= mem[rd_ptr][DATA_WIDTH];
          end
        end
        SGNS: begin
          if (!bus.nrfd && !bus.ndac) begin
            nl_err_q <= 1'b1;
            state    <= IDLE;
            oe_q     <= 1'b0;
            data_q   <= '0;
            eoi_q    <= 1'b0;
          end else begin
            state      <= SDYS;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
          end
        end
        SDYS: begin
          if (settle_done && !bus.nrfd) begin
            state   <= STRS;
            dav_q   <= 1'b1;
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
            state     <= IDLE;
            oe_q      <= 1'b0;
            data_q    <= '0;
            eoi_q     <= 1'b0;
          end else begin
            if (!settle_done) settle_cnt <= settle_cnt + SW'(1);
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        STRS: begin
          if (!bus.ndac) begin
            state <= SWNS;
            dav_q <= 1'b0;
          end else if (tmo_hit) begin
            tmo_err_q <= 1'b1;
            state     <= IDLE;
            dav_q     <= 1'b0;
            oe_q      <= 1'b0;
            data_q    <= '0;
            eoi_q     <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        SWNS: begin
          state  <= IDLE;
          oe_q   <= 1'b0;
          data_q <= '0;
          eoi_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready        = !full;
  assign bus.gpib_data_out   = data_q;
  assign bus.gpib_data_oe    = oe_q;
  assign bus.dav             = dav_q;
  assign bus.eoi_out         = eoi_q;
  assign bus.busy            = (state != IDLE) || (count != '0);
  assign bus.timeout_err     = tmo_err_q;
  assign bus.no_listener_err = nl_err_q;
endmodule
